// File: rtl/fibonacci_seq.sv
// Multi-cycle Fibonacci engine: seeds (a, b) and index n in, term t(n+2) out
// one addition per clock, with start/busy/done handshake, abort and carry flag.
//
// state | meaning
// IDLE  | waiting for start; result registers hold the last job's output
// RUN   | stepping cur/prev once per clock while cnt counts down to zero
module fibonacci_seq #(
  parameter int WIDTH = 32,
  parameter int N_W   = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             clear,
  input  logic [N_W-1:0]   n,
  input  logic [WIDTH-1:0] seed_a,
  input  logic [WIDTH-1:0] seed_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data,
  output logic             overflow
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cur, cur_nxt;
  logic [WIDTH-1:0] prev, prev_nxt;
  logic [N_W-1:0]   cnt, cnt_nxt;
  logic             ovf, ovf_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic             overflow_nxt;
  logic             done_nxt;

  // one extra bit on each sum exposes the carry out of WIDTH
  logic [WIDTH:0]   seed_sum;
  logic [WIDTH:0]   run_sum;

  assign seed_sum = {1'b0, seed_a} + {1'b0, seed_b};
  assign run_sum  = {1'b0, cur} + {1'b0, prev};
  assign busy     = (state == RUN);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      cur      <= '0;
      prev     <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      data     <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cur      <= cur_nxt;
      prev     <= prev_nxt;
      cnt      <= cnt_nxt;
      ovf      <= ovf_nxt;
      data     <= data_nxt;
      overflow <= overflow_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cur_nxt      = cur;
    prev_nxt     = prev;
    cnt_nxt      = cnt;
    ovf_nxt      = ovf;
    data_nxt     = data;
    overflow_nxt = overflow;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !clear) begin
          cur_nxt   = seed_sum[WIDTH-1:0];
          prev_nxt  = seed_b;
          cnt_nxt   = n;
          ovf_nxt   = seed_sum[WIDTH];
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (clear) begin
          state_nxt = IDLE;
        end else if (cnt != '0) begin
          cur_nxt  = run_sum[WIDTH-1:0];
          prev_nxt = cur;
          cnt_nxt  = cnt - 1'b1;
          ovf_nxt  = ovf | run_sum[WIDTH];
        end else begin
          // cur already holds t(n+2); publish it and release the engine
          data_nxt     = cur;
          overflow_nxt = ovf;
          done_nxt     = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fibonacci_seq.sv
// Directed self-checking bench for fibonacci_seq: a 32-bit instance for most
// scenarios and an 8-bit instance for the wrap/overflow cases.
module tb_fibonacci_seq;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;

  logic        start32 = 1'b0, clear32 = 1'b0;
  logic [4:0]  n32 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        busy32, done32, ovf32;
  logic [31:0] data32;

  logic        start8 = 1'b0, clear8 = 1'b0;
  logic [4:0]  n8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, ovf8;
  logic [7:0]  data8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fibonacci_seq #(.WIDTH(32), .N_W(5)) u32 (
    .clk(clk), .resetn(resetn), .start(start32), .clear(clear32), .n(n32),
    .seed_a(a32), .seed_b(b32), .busy(busy32), .done(done32), .data(data32),
    .overflow(ovf32)
  );

  fibonacci_seq #(.WIDTH(8), .N_W(5)) u8 (
    .clk(clk), .resetn(resetn), .start(start8), .clear(clear8), .n(n8),
    .seed_a(a8), .seed_b(b8), .busy(busy8), .done(done8), .data(data8),
    .overflow(ovf8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steps clocks until the selected instance pulses done or the budget runs out.
  task automatic wait_done(input bit w8, input int limit, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!(w8 ? done8 : done32) && cycles < limit);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #2;
    checks++;
    if ({busy32, done32, ovf32, data32} !== 35'd0) begin
      errors++;
      $display("FAIL reset32: busy=%0b done=%0b ovf=%0b data=%0d, want all 0", busy32, done32, ovf32, data32);
    end
    checks++;
    if ({busy8, done8, ovf8, data8} !== 11'd0) begin
      errors++;
      $display("FAIL reset8: busy=%0b done=%0b ovf=%0b data=%0d, want all 0", busy8, done8, ovf8, data8);
    end
    tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int cyc;
    a32 = 0; b32 = 1; n32 = 5; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    checks++;
    if (busy32 !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %0b want 1", busy32);
    end
    wait_done(1'b0, 40, cyc);
    checks++;
    if (cyc !== 6 || done32 !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles done=%0b want 6 and 1", cyc, done32);
    end
    checks++;
    if (data32 !== 32'd13 || ovf32 !== 1'b0 || busy32 !== 1'b0) begin
      errors++;
      $display("FAIL basic_data: data=%0d ovf=%0b busy=%0b want 13 0 0", data32, ovf32, busy32);
    end
    tick();
    checks++;
    if (done32 !== 1'b0 || data32 !== 32'd13) begin
      errors++;
      $display("FAIL basic_pulse: done=%0b data=%0d want 0 13", done32, data32);
    end
  endtask

  task automatic test_n_zero();
    a32 = 3; b32 = 4; n32 = 0; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    checks++;
    if (busy32 !== 1'b1 || done32 !== 1'b0) begin
      errors++;
      $display("FAIL n0_busy: busy=%0b done=%0b want 1 0", busy32, done32);
    end
    tick();
    checks++;
    if (done32 !== 1'b1 || busy32 !== 1'b0 || data32 !== 32'd7) begin
      errors++;
      $display("FAIL n0_done: done=%0b busy=%0b data=%0d want 1 0 7", done32, busy32, data32);
    end
  endtask

  task automatic test_overflow();
    int cyc;
    a8 = 0; b8 = 1; n8 = 12; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_done(1'b1, 40, cyc);
    checks++;
    if (cyc !== 13 || data8 !== 8'd121 || ovf8 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_wrap: cycles=%0d data=%0d ovf=%0b want 13 121 1", cyc, data8, ovf8);
    end
    n8 = 11; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_done(1'b1, 40, cyc);
    checks++;
    if (cyc !== 12 || data8 !== 8'd233 || ovf8 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_reseed: cycles=%0d data=%0d ovf=%0b want 12 233 0", cyc, data8, ovf8);
    end
    // seed addition itself carries: 200+100=300 -> 44, then 44+100=144
    a8 = 200; b8 = 100; n8 = 1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_done(1'b1, 10, cyc);
    checks++;
    if (data8 !== 8'd144 || ovf8 !== 1'b1) begin
      errors++;
      $display("FAIL ovf_seed: data=%0d ovf=%0b want 144 1", data8, ovf8);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    a32 = 0; b32 = 1; n32 = 31; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    cyc = 0;
    repeat (10) begin
      tick();
      cyc++;
    end
    a32 = 5; b32 = 5; n32 = 3; start32 = 1'b1;
    tick();
    cyc++;
    start32 = 1'b0;
    while (!done32 && cyc < 60) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc !== 32 || data32 !== 32'd3524578 || ovf32 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_long: cycles=%0d data=%0d ovf=%0b want 32 3524578 0", cyc, data32, ovf32);
    end
    a32 = 1; b32 = 1; n32 = 2; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    checks++;
    if (busy32 !== 1'b1 || done32 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: busy=%0b done=%0b want 1 0", busy32, done32);
    end
    wait_done(1'b0, 20, cyc);
    checks++;
    if (cyc !== 3 || data32 !== 32'd5) begin
      errors++;
      $display("FAIL b2b_second: cycles=%0d data=%0d want 3 5", cyc, data32);
    end
  endtask

  task automatic test_clear();
    int cyc;
    int seen;
    a32 = 0; b32 = 1; n32 = 10; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    tick();
    tick();
    clear32 = 1'b1;
    tick();
    clear32 = 1'b0;
    checks++;
    if (busy32 !== 1'b0 || done32 !== 1'b0 || data32 !== 32'd5) begin
      errors++;
      $display("FAIL clear_abort: busy=%0b done=%0b data=%0d want 0 0 5", busy32, done32, data32);
    end
    seen = 0;
    repeat (15) begin
      tick();
      if (done32) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL clear_nodone: got %0d done pulses want 0", seen);
    end
    start32 = 1'b1; clear32 = 1'b1;
    tick();
    start32 = 1'b0; clear32 = 1'b0;
    checks++;
    if (busy32 !== 1'b0) begin
      errors++;
      $display("FAIL clear_wins: busy=%0b want 0", busy32);
    end
    a32 = 2; b32 = 3; n32 = 1; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    wait_done(1'b0, 10, cyc);
    checks++;
    if (cyc !== 2 || data32 !== 32'd8) begin
      errors++;
      $display("FAIL clear_restart: cycles=%0d data=%0d want 2 8", cyc, data32);
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    int seen;
    a32 = 0; b32 = 1; n32 = 20; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    tick();
    tick();
    #3;
    resetn = 1'b0;
    #1;
    checks++;
    if ({busy32, done32, ovf32, data32} !== 35'd0) begin
      errors++;
      $display("FAIL areset_now: busy=%0b done=%0b ovf=%0b data=%0d want all 0", busy32, done32, ovf32, data32);
    end
    @(posedge clk);
    #2;
    resetn = 1'b1;
    seen = 0;
    repeat (30) begin
      tick();
      if (done32 || busy32) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL areset_idle: got %0d busy/done cycles want 0", seen);
    end
    a32 = 0; b32 = 1; n32 = 5; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    wait_done(1'b0, 20, cyc);
    checks++;
    if (cyc !== 6 || data32 !== 32'd13) begin
      errors++;
      $display("FAIL areset_restart: cycles=%0d data=%0d want 6 13", cyc, data32);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_n_zero();
    test_overflow();
    test_back_to_back();
    test_clear();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
